// File: rtl/sldma350_trig_arb_pkg.sv
// Shared definitions for the SLDMA350 trigger front-end: DMAC ack/req type codes,
// FSM state encoding and the ack-type decoder.
package sldma350_trig_arb_pkg;

    localparam logic [1:0] ACK_OK    = 2'b00;
    localparam logic [1:0] ACK_DENY  = 2'b01;
    localparam logic [1:0] ACK_FLUSH = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACKLOW = 2'd2
    } state_t;

    typedef struct packed {
        logic deny;   // report through SRC_DENY instead of SRC_DONE
        logic flush;  // clear the pending count instead of decrementing it
    } ack_dec_t;

    // The reserved code 2'b11 falls through as a plain accept.
    function automatic ack_dec_t decode_ack(input logic [1:0] ack_type);
        ack_dec_t d;
        d.deny  = (ack_type == ACK_DENY) || (ack_type == ACK_FLUSH);
        d.flush = (ack_type == ACK_FLUSH);
        return d;
    endfunction

endpackage

// File: rtl/sldma350_rr_arb.sv
// Combinational round-robin arbiter: first asserted request at or after ptr,
// wrapping from NUM_SRC-1 back to 0.
module sldma350_rr_arb #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    int               cand;
    logic [IDX_W-1:0] sel;

    // NOTE: every output gets a default before the search loop, so no path leaves a latch.
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        sel   = '0;
        for (int off = 0; off < NUM_SRC; off++) begin
            cand = int'(ptr) + off;
            if (cand >= NUM_SRC) cand = cand - NUM_SRC;
            sel = IDX_W'(cand);
            if (!valid && req[sel]) begin
                valid      = 1'b1;
                idx        = sel;
                grant[sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sldma350_trig_arb.sv
// Trigger front-end for one DMAC trig_in port: per-source pending counters, round-robin
// source selection and the four-phase req/ack handshake with per-source done/deny pulses.
module sldma350_trig_arb
    import sldma350_trig_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int CNT_W   = 4
) (
    input  logic                   SYS_HCLK,
    input  logic                   SYS_HRESETn,
    input  logic [NUM_SRC-1:0]     SRC_PULSE,
    input  logic [NUM_SRC-1:0]     SRC_EN,
    input  logic [2*NUM_SRC-1:0]   SRC_TYPE,
    input  logic [NUM_SRC-1:0]     OVF_CLR,
    output logic                   TRIG_REQ,
    output logic [1:0]             TRIG_REQ_TYPE,
    input  logic                   TRIG_ACK,
    input  logic [1:0]             TRIG_ACK_TYPE,
    output logic [NUM_SRC-1:0]     SRC_DONE,
    output logic [NUM_SRC-1:0]     SRC_DENY,
    output logic [NUM_SRC-1:0]     SRC_OVF,
    output logic                   BUSY
);

    localparam int               IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt [NUM_SRC];
    logic [NUM_SRC-1:0] pending, inc, dec, ovf_set, ovf_q;
    logic [NUM_SRC-1:0] arb_grant, grant_oh, done_q, deny_q;
    logic [IDX_W-1:0]   arb_idx, grant_idx, rr_ptr;
    logic [1:0]         type_sel, req_type_q;
    logic               arb_valid, grant_load, ack_fire;
    ack_dec_t           ack_dec;

    assign ack_fire = (state == ST_REQ) && TRIG_ACK;
    assign ack_dec  = decode_ack(TRIG_ACK_TYPE);

    always_comb begin
        pending  = '0;
        inc      = '0;
        dec      = '0;
        ovf_set  = '0;
        type_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pending[i] = (cnt[i] != '0);
            inc[i]     = SRC_PULSE[i] & SRC_EN[i];
            dec[i]     = ack_fire & grant_oh[i];
            ovf_set[i] = inc[i] & ~dec[i] & (cnt[i] == CNT_MAX);
            if (arb_grant[i]) type_sel = type_sel | SRC_TYPE[2*i +: 2];
        end
    end

    sldma350_rr_arb #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_rr_arb (
        .req   (pending),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // NOTE: the counter array is a handful of flops, not RAM, so it is reset like any other state.
    always_ff @(posedge SYS_HCLK or negedge SYS_HRESETn) begin
        if (!SYS_HRESETn) begin
            for (int i = 0; i < NUM_SRC; i++) cnt[i] <= '0;
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!SRC_EN[i] || (dec[i] && ack_dec.flush))
                    cnt[i] <= '0;
                else if (inc[i] && !dec[i] && (cnt[i] != CNT_MAX))
                    cnt[i] <= cnt[i] + 1'b1;
                else if (dec[i] && !inc[i] && (cnt[i] != '0))
                    cnt[i] <= cnt[i] - 1'b1;
            end
            ovf_q <= (ovf_q & ~OVF_CLR) | ovf_set;
        end
    end

    // An ack still high from a previous handshake (or a misbehaving DMAC) blocks a new grant.
    always_comb begin
        state_next = state;
        grant_load = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_valid && !TRIG_ACK) begin
                    state_next = ST_REQ;
                    grant_load = 1'b1;
                end
            end
            ST_REQ:    if (TRIG_ACK)  state_next = ST_ACKLOW;
            ST_ACKLOW: if (!TRIG_ACK) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge SYS_HCLK or negedge SYS_HRESETn) begin
        if (!SYS_HRESETn) begin
            state      <= ST_IDLE;
            grant_oh   <= '0;
            grant_idx  <= '0;
            req_type_q <= '0;
            rr_ptr     <= '0;
            done_q     <= '0;
            deny_q     <= '0;
        end else begin
            state <= state_next;
            if (grant_load) begin
                grant_oh   <= arb_grant;
                grant_idx  <= arb_idx;
                req_type_q <= type_sel;
            end
            done_q <= (ack_fire && !ack_dec.deny) ? grant_oh : '0;
            deny_q <= (ack_fire &&  ack_dec.deny) ? grant_oh : '0;
            if (ack_fire)
                rr_ptr <= (grant_idx == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Decoded straight from the state register so reset drops the request without waiting for a clock.
    assign TRIG_REQ      = (state == ST_REQ);
    assign TRIG_REQ_TYPE = (state == ST_REQ) ? req_type_q : 2'b00;
    assign BUSY          = (state != ST_IDLE);
    assign SRC_DONE      = done_q;
    assign SRC_DENY      = deny_q;
    assign SRC_OVF       = ovf_q;

endmodule

// File: tb/tb_sldma350_trig_arb.sv
// Scoreboard bench for sldma350_trig_arb: directed stimulus pushes expected handshakes,
// a DMAC responder acks requests, and a monitor pops and compares every done/deny pulse.
module tb_sldma350_trig_arb;

    localparam int         N     = 4;
    localparam logic [7:0] TYPES = 8'b10_01_11_10;  // src3=10 src2=01 src1=11 src0=10

    logic           SYS_HCLK    = 1'b0;
    logic           SYS_HRESETn = 1'b0;
    logic [N-1:0]   src_pulse   = '0;
    logic [N-1:0]   src_en      = '1;
    logic [2*N-1:0] src_type    = TYPES;
    logic [N-1:0]   ovf_clr     = '0;
    logic           trig_req;
    logic [1:0]     trig_req_type;
    logic           trig_ack;
    logic [1:0]     trig_ack_type;
    logic [N-1:0]   src_done, src_deny, src_ovf;
    logic           busy;

    logic           model_ack  = 1'b0;
    logic [1:0]     model_type = 2'b00;
    logic           man_ack    = 1'b0;
    logic [1:0]     man_type   = 2'b00;
    bit             dmac_en    = 1'b0;

    assign trig_ack      = model_ack | man_ack;
    assign trig_ack_type = model_ack ? model_type : man_type;

    typedef struct {
        logic [N-1:0] done;
        logic [N-1:0] deny;
        logic [1:0]   rtype;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] ack_q[$];
    logic [1:0] rtype_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 SYS_HCLK = ~SYS_HCLK;

    sldma350_trig_arb #(
        .NUM_SRC (N),
        .CNT_W   (2)
    ) dut (
        .SYS_HCLK      (SYS_HCLK),
        .SYS_HRESETn   (SYS_HRESETn),
        .SRC_PULSE     (src_pulse),
        .SRC_EN        (src_en),
        .SRC_TYPE      (src_type),
        .OVF_CLR       (ovf_clr),
        .TRIG_REQ      (trig_req),
        .TRIG_REQ_TYPE (trig_req_type),
        .TRIG_ACK      (trig_ack),
        .TRIG_ACK_TYPE (trig_ack_type),
        .SRC_DONE      (src_done),
        .SRC_DENY      (src_deny),
        .SRC_OVF       (src_ovf),
        .BUSY          (busy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, got, want);
    endtask

    task automatic expect_hs(input int idx, input bit deny);
        exp_t       e;
        logic [7:0] t;
        t       = TYPES;
        e.done  = deny ? '0 : (N'(1) << idx);
        e.deny  = deny ? (N'(1) << idx) : '0;
        e.rtype = t[2*idx +: 2];
        exp_q.push_back(e);
    endtask

    task automatic pulse(input logic [N-1:0] m);
        src_pulse = m;
        @(negedge SYS_HCLK);
        src_pulse = '0;
    endtask

    task automatic do_reset();
        dmac_en     = 1'b0;
        SYS_HRESETn = 1'b0;
        repeat (2) @(negedge SYS_HCLK);
        SYS_HRESETn = 1'b1;
        @(negedge SYS_HCLK);
        check("reset_outputs", {trig_req, trig_req_type, src_done, src_deny, src_ovf, busy}, '0);
    endtask

    task automatic wait_req(input string name);
        for (int k = 0; k < 50 && !trig_req; k++) @(negedge SYS_HCLK);
        check(name, trig_req, 1'b1);
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge SYS_HCLK);
            if (!busy && exp_q.size() == 0) break;
        end
        check({name, "_idle_reached"}, (k < 300), 1'b1);
        repeat (10) @(negedge SYS_HCLK);
        check({name, "_quiet"}, {trig_req, busy}, '0);
        check({name, "_all_seen"}, exp_q.size(), 0);
    endtask

    // DMAC responder: ack three cycles into a request, then release once req drops.
    initial begin
        forever begin
            @(negedge SYS_HCLK);
            if (dmac_en && trig_req && SYS_HRESETn) begin
                repeat (2) @(negedge SYS_HCLK);
                model_type = (ack_q.size() > 0) ? ack_q.pop_front() : 2'b00;
                rtype_q.push_back(trig_req_type);
                model_ack = 1'b1;
                for (int k = 0; k < 50 && trig_req; k++) @(negedge SYS_HCLK);
                model_ack = 1'b0;
            end
        end
    end

    // Monitor: every done/deny pulse must match the oldest expected handshake.
    initial begin
        exp_t        e;
        logic [31:0] r;
        forever begin
            @(negedge SYS_HCLK);
            if ((src_done | src_deny) != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_handshake", {src_done, src_deny}, '0);
                end else begin
                    e = exp_q.pop_front();
                    r = 32'hdead;
                    if (rtype_q.size() > 0) r = 32'(rtype_q.pop_front());
                    check("hs_done", src_done, e.done);
                    check("hs_deny", src_deny, e.deny);
                    check("hs_req_type", r, e.rtype);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        // Single request and its latency
        do_reset();
        dmac_en = 1'b1;
        expect_hs(2, 1'b0);
        pulse(4'b0100);
        check("t1_req_low_after_pulse_edge", trig_req, 1'b0);
        @(negedge SYS_HCLK);
        check("t1_req_high_next_edge", trig_req, 1'b1);
        check("t1_req_type", trig_req_type, 2'b01);
        check("t1_busy", busy, 1'b1);
        wait_idle("t1");

        // Round-robin over four sources, three events each
        do_reset();
        dmac_en = 1'b1;
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < N; i++) expect_hs(i, 1'b0);
        pulse(4'hF);
        @(negedge SYS_HCLK);
        pulse(4'hF);
        @(negedge SYS_HCLK);
        pulse(4'hF);
        wait_idle("t2");

        // Saturation and overflow flag
        do_reset();
        for (int p = 0; p < 3; p++) begin
            pulse(4'b0010);
            @(negedge SYS_HCLK);
        end
        check("t3_no_ovf_at_max", src_ovf, 4'b0000);
        pulse(4'b0010);
        check("t3_ovf_set", src_ovf, 4'b0010);
        @(negedge SYS_HCLK);
        pulse(4'b0010);
        check("t3_ovf_sticky", src_ovf, 4'b0010);
        src_pulse = 4'b0010;
        ovf_clr   = 4'b0010;
        @(negedge SYS_HCLK);
        src_pulse = '0;
        ovf_clr   = '0;
        check("t3_ovf_clr_vs_new_ovf", src_ovf, 4'b0010);
        ovf_clr = 4'b0010;
        @(negedge SYS_HCLK);
        ovf_clr = '0;
        check("t3_ovf_cleared", src_ovf, 4'b0000);
        check("t3_req_held_without_ack", trig_req, 1'b1);
        for (int p = 0; p < 3; p++) expect_hs(1, 1'b0);
        dmac_en = 1'b1;
        wait_idle("t3");

        // Deny then flush
        do_reset();
        for (int p = 0; p < 3; p++) begin
            pulse(4'b0001);
            @(negedge SYS_HCLK);
        end
        ack_q.push_back(2'b01);
        ack_q.push_back(2'b10);
        expect_hs(0, 1'b1);
        expect_hs(0, 1'b1);
        dmac_en = 1'b1;
        wait_idle("t4");
        check("t4_ack_types_used", ack_q.size(), 0);

        // Disable during REQ, then reset during REQ
        do_reset();
        pulse(4'b1000);
        wait_req("t5_req_src3");
        src_en = 4'b0111;
        expect_hs(3, 1'b0);
        dmac_en = 1'b1;
        wait_idle("t5_disable");
        src_en  = 4'b1111;
        dmac_en = 1'b0;
        pulse(4'b0010);
        wait_req("t5_req_src1");
        #2;
        SYS_HRESETn = 1'b0;
        #1;
        check("t5_async_req_drop", {trig_req, busy}, '0);
        @(negedge SYS_HCLK);
        SYS_HRESETn = 1'b1;
        repeat (5) @(negedge SYS_HCLK);
        check("t5_after_reset", {trig_req, busy, src_done, src_deny, src_ovf}, '0);

        // Increment and decrement on the same edge
        do_reset();
        pulse(4'b0001);
        @(negedge SYS_HCLK);
        pulse(4'b0001);
        wait_req("t6_req_src0");
        for (int p = 0; p < 3; p++) expect_hs(0, 1'b0);
        rtype_q.push_back(trig_req_type);
        man_type  = 2'b00;
        man_ack   = 1'b1;
        src_pulse = 4'b0001;
        @(negedge SYS_HCLK);
        src_pulse = '0;
        check("t6_req_dropped_after_ack", trig_req, 1'b0);
        man_ack = 1'b0;
        dmac_en = 1'b1;
        wait_idle("t6_incdec");

        // Ack high while idle blocks the next request
        do_reset();
        man_ack = 1'b1;
        pulse(4'b0100);
        repeat (5) @(negedge SYS_HCLK);
        check("t6_no_req_while_ack_high", {trig_req, busy}, '0);
        man_ack = 1'b0;
        expect_hs(2, 1'b0);
        dmac_en = 1'b1;
        wait_req("t6_req_after_ack_drop");
        wait_idle("t6_proto");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
